// File: rtl/logic_func_pipe.sv
// Two-stage pipelined multi-channel evaluator of the lab logic function
// with per-item mode select, valid/ready backpressure, and a built-in
// exhaustive self-test that sweeps all 16 input combinations.
module logic_func_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] f,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             bist_start,
  input  logic             bist_inject,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_pass,
  output logic [4:0]       bist_errs
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Self-test vector counter
  logic [3:0] n_cnt, n_cnt_next;

  // Stage 1: h, d, mode, valid, plus self-test tag and vector number
  logic             s1_valid;
  logic             s1_bist;
  logic [WIDTH-1:0] s1_h;
  logic [WIDTH-1:0] s1_d;
  logic [1:0]       s1_mode;
  logic [3:0]       s1_n;

  // Stage 2: result, valid, plus self-test tag and vector number
  logic             s2_valid;
  logic             s2_bist;
  logic [WIDTH-1:0] s2_f;
  logic [3:0]       s2_n;

  // Next-value inputs for the stages
  logic             s1_valid_in;
  logic             s1_bist_in;
  logic [WIDTH-1:0] s1_h_in;
  logic [WIDTH-1:0] s1_d_in;
  logic [1:0]       s1_mode_in;
  logic [WIDTH-1:0] s2_f_in;

  logic busy;
  logic user_ok;
  logic advance;
  logic accept;
  logic start_bist;
  logic golden_bit;
  logic mismatch;
  logic [4:0] errs;

  assign busy       = (state == SWEEP) || (state == DRAIN);
  assign user_ok    = (state == IDLE) || (state == DONE);
  // Self-test results never leave the block, so they don't count as output
  assign out_valid  = s2_valid && !s2_bist && !busy;
  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance && user_ok;
  assign accept     = in_valid && in_ready;
  assign start_bist = bist_start && user_ok;
  assign f          = s2_f;

  assign bist_busy  = busy;
  assign bist_done  = (state == DONE);
  assign bist_pass  = (state == DONE) && (errs == 5'd0);
  assign bist_errs  = errs;

  // Golden result for the vector currently in stage 2 (mode 0 lab function)
  assign golden_bit = s2_n[0] & ~((s2_n[3] & s2_n[2]) | s2_n[1]);
  assign mismatch   = (s2_f != {WIDTH{golden_bit}});

  // Self-test state register and vector counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      n_cnt <= 4'd0;
    end else begin
      state <= state_next;
      n_cnt <= n_cnt_next;
    end
  end

  // Self-test sequencing: sweep 16 vectors, drain the pipe, then report
  always_comb begin
    state_next = state;
    n_cnt_next = n_cnt;
    unique case (state)
      IDLE, DONE: begin
        if (bist_start) begin
          state_next = SWEEP;
          n_cnt_next = 4'd0;
        end
      end
      SWEEP: begin
        n_cnt_next = n_cnt + 4'd1;
        if (n_cnt == 4'hF) state_next = DRAIN;
      end
      DRAIN: begin
        if (s2_valid && s2_bist && (s2_n == 4'hF)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage-1 source: sweep vectors own the pipe while sweeping, else the ports
  always_comb begin
    s1_valid_in = accept;
    s1_bist_in  = 1'b0;
    s1_h_in     = (a & b) | c;
    s1_d_in     = d;
    s1_mode_in  = mode;
    if (state == SWEEP) begin
      s1_valid_in = 1'b1;
      s1_bist_in  = 1'b1;
      s1_h_in     = {WIDTH{(n_cnt[3] & n_cnt[2]) | n_cnt[1]}};
      s1_d_in     = {WIDTH{n_cnt[0]}};
      s1_mode_in  = 2'd0;
    end
  end

  // Stage-2 function select, with optional bit-0 corruption of sweep results
  always_comb begin
    s2_f_in = '0;
    case (s1_mode)
      2'd0:    s2_f_in = s1_d & ~s1_h;
      2'd1:    s2_f_in = s1_h;
      2'd2:    s2_f_in = s1_h | s1_d;
      default: s2_f_in = s1_h ^ s1_d;
    endcase
    if (s1_bist && bist_inject) s2_f_in[0] = ~s2_f_in[0];
  end

  // Pipeline registers; starting a self-test flushes any user items in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_bist  <= 1'b0;
      s1_h     <= '0;
      s1_d     <= '0;
      s1_mode  <= 2'd0;
      s1_n     <= 4'd0;
      s2_valid <= 1'b0;
      s2_bist  <= 1'b0;
      s2_f     <= '0;
      s2_n     <= 4'd0;
    end else if (start_bist) begin
      s1_valid <= 1'b0;
      s1_bist  <= 1'b0;
      s2_valid <= 1'b0;
      s2_bist  <= 1'b0;
    end else if (advance) begin
      s1_valid <= s1_valid_in;
      s1_bist  <= s1_bist_in;
      s1_h     <= s1_h_in;
      s1_d     <= s1_d_in;
      s1_mode  <= s1_mode_in;
      s1_n     <= n_cnt;
      s2_valid <= s1_valid;
      s2_bist  <= s1_bist;
      s2_f     <= s2_f_in;
      s2_n     <= s1_n;
    end
  end

  // Mismatch counter: one count per wrong vector, saturating at 16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errs <= 5'd0;
    end else if (start_bist) begin
      errs <= 5'd0;
    end else if (busy && s2_valid && s2_bist && mismatch && (errs != 5'd16)) begin
      errs <= errs + 5'd1;
    end
  end

endmodule

// File: tb/tb_logic_func_pipe.sv
// Self-checking bench for logic_func_pipe: directed traffic, backpressure,
// randomized streams against a queue-based reference, and self-test runs.
module tb_logic_func_pipe;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a, b, c, d;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] f;
  logic             out_valid;
  logic             out_ready;
  logic             bist_start;
  logic             bist_inject;
  logic             bist_busy;
  logic             bist_done;
  logic             bist_pass;
  logic [4:0]       bist_errs;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             stalled_prev;
  logic [WIDTH-1:0] held_f;

  logic_func_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .f(f),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bist_start(bist_start),
    .bist_inject(bist_inject),
    .bist_busy(bist_busy),
    .bist_done(bist_done),
    .bist_pass(bist_pass),
    .bist_errs(bist_errs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: evaluate the selected function channel by channel with booleans
  function automatic logic [WIDTH-1:0] modelF(input logic [WIDTH-1:0] ma, mb, mc, md,
                                             input logic [1:0] mm);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bit h;
      bit dv;
      h  = (ma[i] && mb[i]) || mc[i];
      dv = md[i];
      case (mm)
        2'd0: r[i] = dv && !h;
        2'd1: r[i] = h;
        2'd2: r[i] = h || dv;
        default: r[i] = (h != dv);
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of traffic: drive at the falling edge, score, then cross a rising edge
  task automatic applyStimulus(input logic [WIDTH-1:0] ia, ib, ic, id,
                               input logic [1:0] im, input logic iv, input logic ordy,
                               output logic acc);
    logic [WIDTH-1:0] e;
    if (stalled_prev) begin
      checkOutput("stall_hold_f", f, held_f);
      checkOutput("stall_hold_valid", out_valid, 1);
    end
    a = ia; b = ib; c = ic; d = id; mode = im;
    in_valid = iv; out_ready = ordy;
    #1;
    stalled_prev = out_valid && !out_ready;
    held_f = f;
    if (out_valid && !out_ready) checkOutput("stall_in_ready", in_ready, 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_output", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("stream_f", f, e);
      end
    end
    acc = iv && in_ready;
    if (acc) exp_q.push_back(modelF(ia, ib, ic, id, im));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drainAll();
    logic acc;
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
      applyStimulus('0, '0, '0, '0, 2'd0, 1'b0, 1'b1, acc);
      guard++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
    checkOutput("drain_out_valid", out_valid, 0);
  endtask

  task automatic pulseBistStart();
    in_valid = 1'b0;
    out_ready = 1'b1;
    bist_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bist_start = 1'b0;
    stalled_prev = 1'b0;
    exp_q.delete();
  endtask

  task automatic runBist(input logic inject, input logic in_flight);
    logic acc;
    int busy_cycles;
    int exp_errs;
    bist_inject = inject;
    if (in_flight) begin
      applyStimulus(4'h3, 4'h5, 4'h0, 4'hF, 2'd0, 1'b1, 1'b1, acc);
      checkOutput("inflight_accept", acc, 1);
    end
    pulseBistStart();
    if (in_flight) checkOutput("inflight_discard", out_valid, 0);
    busy_cycles = 0;
    while (bist_busy && busy_cycles < 100) begin
      checkOutput("sweep_out_valid", out_valid, 0);
      checkOutput("sweep_in_ready", in_ready, 0);
      busy_cycles++;
      @(negedge clk);
    end
    checkOutput("bist_busy_cycles", busy_cycles, 18);
    exp_errs = 0;
    for (int n = 0; n < 16; n++) begin
      bit gold;
      bit got;
      gold = (n == 1) || (n == 5) || (n == 9);
      got  = inject ? !gold : gold;
      if (got != gold && exp_errs < 16) exp_errs++;
    end
    checkOutput("bist_done", bist_done, 1);
    checkOutput("bist_pass", bist_pass, (exp_errs == 0));
    checkOutput("bist_errs", bist_errs, exp_errs);
    checkOutput("done_in_ready", in_ready, 1);
    bist_inject = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("done_hold", bist_done, 1);
    checkOutput("done_hold_errs", bist_errs, exp_errs);
  endtask

  task automatic randomTraffic(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
                    WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 7), acc);
    end
    drainAll();
  endtask

  initial begin
    logic acc;
    int idx;
    int cyc;
    rst_n = 1'b0;
    a = '0; b = '0; c = '0; d = '0; mode = 2'd0;
    in_valid = 1'b0; out_ready = 1'b1;
    bist_start = 1'b0; bist_inject = 1'b0;
    stalled_prev = 1'b0;
    held_f = '0;
    #3;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_f", f, 0);
    checkOutput("reset_busy", bist_busy, 0);
    checkOutput("reset_done", bist_done, 0);
    checkOutput("reset_pass", bist_pass, 0);
    checkOutput("reset_errs", bist_errs, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", in_ready, 1);

    $display("[TB] directed mode 0 latency");
    applyStimulus(4'b0011, 4'b0101, 4'b0000, 4'b1111, 2'd0, 1'b1, 1'b1, acc);
    checkOutput("lat_accept", acc, 1);
    checkOutput("lat_cycle1", out_valid, 0);
    applyStimulus('0, '0, '0, '0, 2'd0, 1'b0, 1'b1, acc);
    checkOutput("lat_cycle2", out_valid, 1);
    checkOutput("lat_f", f, 4'b1110);
    drainAll();

    $display("[TB] mode sweep");
    for (int m = 0; m < 4; m++)
      applyStimulus(4'b0011, 4'b0101, 4'b0000, 4'b1111, 2'(m), 1'b1, 1'b1, acc);
    drainAll();

    $display("[TB] backpressure");
    idx = 0;
    cyc = 0;
    while ((idx < 4 || exp_q.size() != 0) && cyc < 30) begin
      applyStimulus(4'(idx), 4'hF, 4'(idx + 2), 4'(~idx), 2'(idx), (idx < 4),
                    !(cyc >= 2 && cyc <= 4), acc);
      if (acc) idx++;
      cyc++;
    end
    checkOutput("bp_all_sent", idx, 4);
    drainAll();

    $display("[TB] random traffic");
    randomTraffic(80);

    $display("[TB] self-test clean");
    runBist(1'b0, 1'b0);
    randomTraffic(20);

    $display("[TB] self-test with injection");
    runBist(1'b1, 1'b0);

    $display("[TB] self-test over in-flight item");
    runBist(1'b0, 1'b1);
    drainAll();

    $display("[TB] reset mid-sweep");
    pulseBistStart();
    repeat (5) @(negedge clk);
    checkOutput("midsweep_busy", bist_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", bist_busy, 0);
    checkOutput("abort_done", bist_done, 0);
    checkOutput("abort_pass", bist_pass, 0);
    checkOutput("abort_errs", bist_errs, 0);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_f", f, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_in_ready", in_ready, 1);
    randomTraffic(20);
    runBist(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
